fmul_trace_monitor: RTL and testbench
=====================================

# fmul_trace_monitor

Synthesizable, parametrised trace monitor for the Mini-RISC-V FMUL core. It sits beside the core and snoops the decoded-FMUL operand/result bus and the data-memory write port. Each event is captured as a timestamped entry in a circular buffer that a host or bench drains through a pop interface. It also detects halt, with a drain window, and provides a cycle-budget watchdog, replacing the behavioural tracing and timeout done in simulation-only code.

## Interface
Parameters:
- XLEN, 32: operand/result/data width.
- AW, 32: DMEM address width.
- DEPTH, 16: buffer entries; power of two, ≥ 4.
- TIMEOUT_CYCLES, 1000: watchdog budget in clk cycles, ≥ 2.
- DRAIN_CYCLES, 2: cycles captured after halt before stopping, ≥ 0.

Ports:
- clk, in, 1: single clock; all state updates on posedge.
- rst, in, 1: reset, asynchronous and active-high.
- fmul_valid, in, 1: FMUL decoded this cycle.
- fmul_a / fmul_b / fmul_p, in, XLEN each: operands and product.
- dmem_we, in, 1: data-memory write strobe.
- dmem_addr, in, AW: write address.
- dmem_wdata, in, XLEN: write data.
- halted, in, 1: core halt flag (level).
- rd_en, in, 1: pop request.
- rd_valid, out, 1: registered pop-data strobe.
- rd_kind, out, 2: 2'b01 FMUL, 2'b10 DMEM.
- rd_w0 / rd_w1 / rd_w2, out, XLEN each: FMUL gives A/B/P. DMEM gives addr (zero-extended or truncated to XLEN), wdata, 0.
- rd_time, out, 32: capture timestamp.
- count, out, $clog2(DEPTH)+1: entries held.
- overflow, out, 1: sticky; an event was dropped.
- drop_cnt, out, 16: dropped events, saturating at 16'hFFFF.
- done, out, 1: state DONE.
- timeout, out, 1: state TIMEOUT.
- cycle, out, 32: free-running cycle counter.

## Operation
- States: RUN, DRAIN, DONE, TIMEOUT. Reset enters RUN.
- RUN captures events.
  - halted=1 with DRAIN_CYCLES>0 → DRAIN, drain counter loaded with DRAIN_CYCLES.
  - halted=1 with DRAIN_CYCLES=0 → DONE.
  - Otherwise, cycle==TIMEOUT_CYCLES-1 → TIMEOUT.
- DRAIN captures events and decrements the drain counter each cycle.
  - Counter reaches 1 → DONE, so exactly DRAIN_CYCLES cycles of capture occur after the halt cycle.
  - Timeout is still checked and loses to halt/drain completion in the same cycle.
- DONE and TIMEOUT are terminal until rst. Capture stops; pop still works.
- Halt and timeout in the same cycle: halt wins.
- cycle increments every cycle in RUN/DRAIN and freezes in DONE/TIMEOUT.
- Capture happens in the sampling cycle (RUN/DRAIN, including the halt cycle). Timestamp = cycle value at that edge.
- Simultaneous FMUL and DMEM events: both written the same cycle, FMUL at wr_ptr and DMEM at wr_ptr+1 (mod DEPTH).
- Capacity check uses free = DEPTH − count, taken before this cycle's pop.
  - 0 free: all events this cycle dropped.
  - 1 free with two events: FMUL kept, DMEM dropped.
  - Each dropped event increments drop_cnt and sets overflow.
- Pop: rd_en with count>0 reads the rd_ptr entry into the output registers and advances rd_ptr. rd_en with count==0 is ignored (rd_valid=0, outputs hold).
- Pointers wrap modulo DEPTH. count_next = count + pushes − pop.

## Timing
- Reset values:
  - count, rd_valid, overflow, drop_cnt, cycle, done, timeout = 0.
  - rd_kind, rd_w*, rd_time = 0.
  - Pointers = 0; state RUN.
- Events sampled at edge N are reflected in count after edge N. Earliest pop of a captured entry is at edge N+1.
- Pop latency is 1: rd_en high at edge N gives rd_valid=1 and data during cycle N..N+1. rd_valid is a one-cycle pulse per pop, so back-to-back pops give back-to-back strobes.
- Push and pop in the same cycle are allowed. When full, a same-cycle pop does not make room.
- done/timeout assert the cycle after the transition edge.
- rst asserted mid-operation clears everything immediately. Buffer contents need not be cleared but are unreachable.

## Test plan
- FMUL A=3F800000 B=40000000 P=40000000 at cycle 5, then pop → rd_valid=1, kind=01, w0/w1/w2 = those values, rd_time=5, count 1→0.
- Same cycle: FMUL (40400000×40400000→41100000) plus DMEM write addr=00000010 wdata=41100000 → count+2. Pops return FMUL first, then DMEM with equal timestamps.
- 20 FMUL events into DEPTH=16 with no pops → count=16, overflow=1, drop_cnt=4. Pops return the first 16 in order, verifying pointer wrap after a refill.
- halted rises at cycle 30 with DRAIN_CYCLES=2 → a DMEM write at cycle 32 is captured, one at cycle 33 is not; done=1 after edge 32; cycle frozen at 33.
- No halt, TIMEOUT_CYCLES=50 → timeout=1 after edge 49, capture stops; halted at cycle 49 instead → done path, timeout stays 0.
- rst pulsed mid-run with 5 entries held → all outputs at reset values asynchronously, count=0, and capture resumes after release.

Source files
------------

// File: rtl/fmul_trace_monitor_if.sv
// Snoop/drain bus of the FMUL trace monitor: core-side event inputs plus the pop port.
// The slave modport is the monitor; the master modport is the core/host side.
interface fmul_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 16
) ();
  logic                       fmul_valid;
  logic [XLEN-1:0]            fmul_a;
  logic [XLEN-1:0]            fmul_b;
  logic [XLEN-1:0]            fmul_p;
  logic                       dmem_we;
  logic [AW-1:0]              dmem_addr;
  logic [XLEN-1:0]            dmem_wdata;
  logic                       halted;
  logic                       rd_en;
  logic                       rd_valid;
  logic [1:0]                 rd_kind;
  logic [XLEN-1:0]            rd_w0;
  logic [XLEN-1:0]            rd_w1;
  logic [XLEN-1:0]            rd_w2;
  logic [31:0]                rd_time;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [15:0]                drop_cnt;
  logic                       done;
  logic                       timeout;
  logic [31:0]                cycle;

  modport slave (
    input  fmul_valid, fmul_a, fmul_b, fmul_p, dmem_we, dmem_addr, dmem_wdata, halted, rd_en,
    output rd_valid, rd_kind, rd_w0, rd_w1, rd_w2, rd_time, count, overflow, drop_cnt,
           done, timeout, cycle
  );

  modport master (
    output fmul_valid, fmul_a, fmul_b, fmul_p, dmem_we, dmem_addr, dmem_wdata, halted, rd_en,
    input  rd_valid, rd_kind, rd_w0, rd_w1, rd_w2, rd_time, count, overflow, drop_cnt,
           done, timeout, cycle
  );
endinterface

// File: rtl/fmul_trace_monitor.sv
// Trace monitor for the FMUL core: timestamps FMUL and DMEM-write events into a circular
// buffer drained through a registered pop port, with halt/drain detection and a watchdog.
module fmul_trace_monitor #(
  parameter int XLEN           = 32,
  parameter int AW             = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DRAIN_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fmul_trace_monitor_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam bit HAS_DRAIN = (DRAIN_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t            state_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [31:0]       cycle_r;
  logic [31:0]       drain_cnt_r;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;
  logic              done_r;
  logic              timeout_r;
  logic              rd_valid_r;
  logic [1:0]        rd_kind_r;
  logic [XLEN-1:0]   rd_w0_r;
  logic [XLEN-1:0]   rd_w1_r;
  logic [XLEN-1:0]   rd_w2_r;
  logic [31:0]       rd_time_r;

  logic [1:0]        kind_mem [DEPTH];
  logic [XLEN-1:0]   w0_mem   [DEPTH];
  logic [XLEN-1:0]   w1_mem   [DEPTH];
  logic [XLEN-1:0]   w2_mem   [DEPTH];
  logic [31:0]       time_mem [DEPTH];

  logic              capture_s;
  logic              fmul_ev_s;
  logic              dmem_ev_s;
  logic              pop_s;
  logic [CW-1:0]     free_s;
  logic              keep_fmul_s;
  logic              keep_dmem_s;
  logic [1:0]        push_n_s;
  logic [1:0]        drop_n_s;
  logic [PW-1:0]     dmem_idx_s;
  logic [16:0]       drop_sum_s;
  logic [15:0]       drop_next_s;

  assign capture_s  = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign fmul_ev_s  = capture_s & bus.fmul_valid;
  assign dmem_ev_s  = capture_s & bus.dmem_we;
  assign pop_s      = bus.rd_en && (count_r != {CW{1'b0}});
  // Free space is judged before this cycle's pop, so a pop never makes room for a push.
  assign free_s     = CW'(DEPTH) - count_r;

  // Decide which of this cycle's events fit; FMUL takes precedence for the last slot.
  always_comb begin
    keep_fmul_s = 1'b0;
    keep_dmem_s = 1'b0;
    if (free_s == {CW{1'b0}}) begin
      keep_fmul_s = 1'b0;
      keep_dmem_s = 1'b0;
    end else if (free_s == CW'(1)) begin
      keep_fmul_s = fmul_ev_s;
      keep_dmem_s = dmem_ev_s & ~fmul_ev_s;
    end else begin
      keep_fmul_s = fmul_ev_s;
      keep_dmem_s = dmem_ev_s;
    end
  end

  assign push_n_s    = {1'b0, keep_fmul_s} + {1'b0, keep_dmem_s};
  assign drop_n_s    = ({1'b0, fmul_ev_s} + {1'b0, dmem_ev_s}) - push_n_s;
  assign dmem_idx_s  = keep_fmul_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
  assign drop_sum_s  = {1'b0, drop_cnt_r} + 17'(drop_n_s);
  assign drop_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];

  // Entry storage; contents survive reset but the cleared pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (keep_fmul_s) begin
      kind_mem[wr_ptr_r] <= 2'b01;
      w0_mem[wr_ptr_r]   <= bus.fmul_a;
      w1_mem[wr_ptr_r]   <= bus.fmul_b;
      w2_mem[wr_ptr_r]   <= bus.fmul_p;
      time_mem[wr_ptr_r] <= cycle_r;
    end
    if (keep_dmem_s) begin
      kind_mem[dmem_idx_s] <= 2'b10;
      w0_mem[dmem_idx_s]   <= XLEN'(bus.dmem_addr);
      w1_mem[dmem_idx_s]   <= bus.dmem_wdata;
      w2_mem[dmem_idx_s]   <= {XLEN{1'b0}};
      time_mem[dmem_idx_s] <= cycle_r;
    end
  end

  // Run/drain/terminal state machine together with buffer bookkeeping and pop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      cycle_r     <= 32'd0;
      drain_cnt_r <= 32'd0;
      overflow_r  <= 1'b0;
      drop_cnt_r  <= 16'd0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_kind_r   <= 2'b00;
      rd_w0_r     <= {XLEN{1'b0}};
      rd_w1_r     <= {XLEN{1'b0}};
      rd_w2_r     <= {XLEN{1'b0}};
      rd_time_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.halted) begin
            if (HAS_DRAIN) begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= 32'(DRAIN_CYCLES);
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else if (cycle_r == 32'(TIMEOUT_CYCLES - 1)) begin
            state_r   <= ST_TIMEOUT;
            timeout_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 32'd1) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (cycle_r == 32'(TIMEOUT_CYCLES - 1)) begin
            state_r   <= ST_TIMEOUT;
            timeout_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 32'd1;
          end
        end
        ST_DONE:    state_r <= ST_DONE;
        ST_TIMEOUT: state_r <= ST_TIMEOUT;
        default:    state_r <= ST_RUN;
      endcase

      if (capture_s) begin
        cycle_r <= cycle_r + 32'd1;
      end

      wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
      count_r  <= count_r + CW'(push_n_s) - CW'(pop_s);

      if (drop_n_s != 2'd0) begin
        overflow_r <= 1'b1;
        drop_cnt_r <= drop_next_s;
      end

      rd_valid_r <= pop_s;
      if (pop_s) begin
        rd_kind_r <= kind_mem[rd_ptr_r];
        rd_w0_r   <= w0_mem[rd_ptr_r];
        rd_w1_r   <= w1_mem[rd_ptr_r];
        rd_w2_r   <= w2_mem[rd_ptr_r];
        rd_time_r <= time_mem[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_kind  = rd_kind_r;
  assign bus.rd_w0    = rd_w0_r;
  assign bus.rd_w1    = rd_w1_r;
  assign bus.rd_w2    = rd_w2_r;
  assign bus.rd_time  = rd_time_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.drop_cnt = drop_cnt_r;
  assign bus.done     = done_r;
  assign bus.timeout  = timeout_r;
  assign bus.cycle    = cycle_r;

endmodule

// File: tb/tb_fmul_trace_monitor.sv
// Directed bench for fmul_trace_monitor (DEPTH=16, TIMEOUT_CYCLES=50, DRAIN_CYCLES=2).
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_fmul_trace_monitor;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;

  fmul_trace_monitor_if #(.XLEN(32), .AW(32), .DEPTH(16)) bus ();

  fmul_trace_monitor #(
    .XLEN(32), .AW(32), .DEPTH(16), .TIMEOUT_CYCLES(50), .DRAIN_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_inputs();
    bus.fmul_valid = 1'b0;
    bus.fmul_a     = 32'd0;
    bus.fmul_b     = 32'd0;
    bus.fmul_p     = 32'd0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 32'd0;
    bus.dmem_wdata = 32'd0;
    bus.halted     = 1'b0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    check_eq("rst_count",    64'(bus.count),    64'd0);
    check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("rst_overflow", 64'(bus.overflow), 64'd0);
    check_eq("rst_drop",     64'(bus.drop_cnt), 64'd0);
    check_eq("rst_cycle",    64'(bus.cycle),    64'd0);
    check_eq("rst_done",     64'(bus.done),     64'd0);
    check_eq("rst_timeout",  64'(bus.timeout),  64'd0);
    check_eq("rst_kind",     64'(bus.rd_kind),  64'd0);
    check_eq("rst_w0",       64'(bus.rd_w0),    64'd0);
    check_eq("rst_time",     64'(bus.rd_time),  64'd0);

    // Single FMUL at cycle 5, then pop
    idle(5);
    check_eq("t1_cycle5", 64'(bus.cycle), 64'd5);
    bus.fmul_valid = 1'b1;
    bus.fmul_a = 32'h3F800000; bus.fmul_b = 32'h40000000; bus.fmul_p = 32'h40000000;
    tick();
    bus.fmul_valid = 1'b0;
    check_eq("t1_count1", 64'(bus.count), 64'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t1_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("t1_kind",  64'(bus.rd_kind),  64'd1);
    check_eq("t1_w0",    64'(bus.rd_w0),    64'h3F800000);
    check_eq("t1_w1",    64'(bus.rd_w1),    64'h40000000);
    check_eq("t1_w2",    64'(bus.rd_w2),    64'h40000000);
    check_eq("t1_time",  64'(bus.rd_time),  64'd5);
    check_eq("t1_count0", 64'(bus.count),   64'd0);
    tick();
    check_eq("t1_pulse", 64'(bus.rd_valid), 64'd0);
    // Pop on empty is ignored and outputs hold
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t1_empty_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("t1_empty_hold",  64'(bus.rd_w0),    64'h3F800000);
    check_eq("t1_cycle9",      64'(bus.cycle),    64'd9);

    // Simultaneous FMUL + DMEM at cycle 9
    bus.fmul_valid = 1'b1;
    bus.fmul_a = 32'h40400000; bus.fmul_b = 32'h40400000; bus.fmul_p = 32'h41100000;
    bus.dmem_we = 1'b1; bus.dmem_addr = 32'h00000010; bus.dmem_wdata = 32'h41100000;
    tick();
    bus.fmul_valid = 1'b0;
    bus.dmem_we = 1'b0;
    check_eq("t2_count2", 64'(bus.count), 64'd2);
    bus.rd_en = 1'b1;
    tick();
    check_eq("t2_kind_f", 64'(bus.rd_kind), 64'd1);
    check_eq("t2_p",      64'(bus.rd_w2),   64'h41100000);
    check_eq("t2_time_f", 64'(bus.rd_time), 64'd9);
    tick();
    bus.rd_en = 1'b0;
    check_eq("t2_valid_d", 64'(bus.rd_valid), 64'd1);
    check_eq("t2_kind_d",  64'(bus.rd_kind),  64'd2);
    check_eq("t2_addr",    64'(bus.rd_w0),    64'h00000010);
    check_eq("t2_wdata",   64'(bus.rd_w1),    64'h41100000);
    check_eq("t2_zero",    64'(bus.rd_w2),    64'd0);
    check_eq("t2_time_d",  64'(bus.rd_time),  64'd9);
    check_eq("t2_count0",  64'(bus.count),    64'd0);

    // Overflow: 20 FMULs into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.fmul_valid = 1'b1;
      bus.fmul_a = 32'h1000 + 32'(i);
      bus.fmul_b = 32'h2000 + 32'(i);
      bus.fmul_p = 32'h3000 + 32'(i);
      tick();
    end
    bus.fmul_valid = 1'b0;
    check_eq("t3_full",     64'(bus.count),    64'd16);
    check_eq("t3_overflow", 64'(bus.overflow), 64'd1);
    check_eq("t3_drop4",    64'(bus.drop_cnt), 64'd4);
    // Pop while full with a new event: the event is still dropped
    bus.rd_en = 1'b1;
    bus.fmul_valid = 1'b1;
    bus.fmul_a = 32'hDEAD0000;
    tick();
    bus.fmul_valid = 1'b0;
    check_eq("t3_pop0_w0",   64'(bus.rd_w0),    64'h1000);
    check_eq("t3_pop0_time", 64'(bus.rd_time),  64'd0);
    check_eq("t3_count15",   64'(bus.count),    64'd15);
    check_eq("t3_drop5",     64'(bus.drop_cnt), 64'd5);
    for (int i = 1; i < 16; i++) begin
      tick();
      check_eq("t3_pop_w0",   64'(bus.rd_w0),   64'h1000 + 64'(i));
      check_eq("t3_pop_w2",   64'(bus.rd_w2),   64'h3000 + 64'(i));
      check_eq("t3_pop_time", 64'(bus.rd_time), 64'(i));
    end
    bus.rd_en = 1'b0;
    check_eq("t3_empty", 64'(bus.count), 64'd0);
    // Refill after the pointers wrapped
    for (int j = 0; j < 3; j++) begin
      bus.fmul_valid = 1'b1;
      bus.fmul_a = 32'h4000 + 32'(j);
      tick();
    end
    bus.fmul_valid = 1'b0;
    check_eq("t3_refill", 64'(bus.count), 64'd3);
    bus.rd_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_eq("t3_re_w0",   64'(bus.rd_w0),   64'h4000 + 64'(j));
      check_eq("t3_re_time", 64'(bus.rd_time), 64'd36 + 64'(j));
    end
    bus.rd_en = 1'b0;

    // Halt at cycle 30 with two drain cycles
    do_reset();
    idle(30);
    bus.halted = 1'b1;
    tick();
    check_eq("t4_done_e30", 64'(bus.done), 64'd0);
    tick();
    check_eq("t4_done_e31", 64'(bus.done), 64'd0);
    bus.dmem_we = 1'b1; bus.dmem_addr = 32'h20; bus.dmem_wdata = 32'hAA;
    tick();
    check_eq("t4_done_e32", 64'(bus.done),  64'd1);
    check_eq("t4_count1",   64'(bus.count), 64'd1);
    bus.dmem_addr = 32'h24; bus.dmem_wdata = 32'hBB;
    tick();
    bus.dmem_we = 1'b0;
    check_eq("t4_no_capture", 64'(bus.count),   64'd1);
    check_eq("t4_cycle33",    64'(bus.cycle),   64'd33);
    check_eq("t4_timeout0",   64'(bus.timeout), 64'd0);
    tick();
    check_eq("t4_frozen", 64'(bus.cycle), 64'd33);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t4_kind", 64'(bus.rd_kind), 64'd2);
    check_eq("t4_addr", 64'(bus.rd_w0),   64'h20);
    check_eq("t4_data", 64'(bus.rd_w1),   64'hAA);
    check_eq("t4_time", 64'(bus.rd_time), 64'd32);
    bus.halted = 1'b0;

    // Timeout at edge 49
    do_reset();
    idle(49);
    check_eq("t5_pre_timeout", 64'(bus.timeout), 64'd0);
    bus.fmul_valid = 1'b1;
    tick();
    check_eq("t5_timeout", 64'(bus.timeout), 64'd1);
    check_eq("t5_done0",   64'(bus.done),    64'd0);
    check_eq("t5_cap49",   64'(bus.count),   64'd1);
    check_eq("t5_cycle50", 64'(bus.cycle),   64'd50);
    tick();
    bus.fmul_valid = 1'b0;
    check_eq("t5_stopped", 64'(bus.count), 64'd1);
    check_eq("t5_frozen",  64'(bus.cycle), 64'd50);

    // Halt and timeout in the same cycle: halt wins
    do_reset();
    idle(49);
    bus.halted = 1'b1;
    tick();
    check_eq("t5b_timeout0", 64'(bus.timeout), 64'd0);
    tick();
    tick();
    check_eq("t5b_done",     64'(bus.done),    64'd1);
    check_eq("t5b_timeout1", 64'(bus.timeout), 64'd0);
    bus.halted = 1'b0;

    // Asynchronous reset mid-run with 5 entries held
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.fmul_valid = 1'b1;
      bus.fmul_a = 32'h5000 + 32'(i);
      tick();
    end
    bus.fmul_valid = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t6_count5", 64'(bus.count),    64'd5);
    check_eq("t6_valid",  64'(bus.rd_valid), 64'd1);
    check_eq("t6_w0",     64'(bus.rd_w0),    64'h5000);
    rst = 1'b1;
    #2;
    check_eq("t6_async_count", 64'(bus.count),    64'd0);
    check_eq("t6_async_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("t6_async_w0",    64'(bus.rd_w0),    64'd0);
    check_eq("t6_async_cycle", 64'(bus.cycle),    64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fmul_valid = 1'b1;
    bus.fmul_a = 32'h6000;
    tick();
    bus.fmul_valid = 1'b0;
    check_eq("t6_resume_count", 64'(bus.count), 64'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t6_resume_w0",   64'(bus.rd_w0),   64'h6000);
    check_eq("t6_resume_time", 64'(bus.rd_time), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
